// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control FSM: state encoding,
// opcode/funct values, ALU op codes and datapath mux select encodings.
package ctrl_pkg;

    typedef enum logic [4:0] {
        FETCH     = 5'd0,
        FETCH_LAT = 5'd1,
        DECODE    = 5'd2,
        R_EXEC    = 5'd3,
        R_WB      = 5'd4,
        JR        = 5'd5,
        I_EXEC    = 5'd6,
        I_WB      = 5'd7,
        BRANCH    = 5'd8,
        JUMP      = 5'd9,
        JAL       = 5'd10,
        MEM_ADDR  = 5'd11,
        LW_RD     = 5'd12,
        LW_WAIT   = 5'd13,
        LW_WB     = 5'd14,
        SW_WR     = 5'd15,
        HALT      = 5'd16
    } state_t;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_IMM_10 = 6'h10;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;
    localparam logic [5:0] OP_HALT   = 6'h3F;

    // R-type funct selecting jump-register
    localparam logic [5:0] FUNCT_JR  = 6'h08;

    // ALU control: 6'h00 means "decode funct", this value means plain add
    localparam logic [5:0] ALU_OP_RTYPE = 6'h00;
    localparam logic [5:0] ALU_OP_ADD   = 6'h3E;

    // ALU B-operand select
    localparam logic [1:0] ALU_B_REG     = 2'b00;
    localparam logic [1:0] ALU_B_FOUR    = 2'b01;
    localparam logic [1:0] ALU_B_IMM     = 2'b10;
    localparam logic [1:0] ALU_B_IMM_SH2 = 2'b11;

    // PC next-value select
    localparam logic [1:0] PC_SRC_ALU     = 2'b00;
    localparam logic [1:0] PC_SRC_ALU_OUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP    = 2'b10;

    // Logical immediates (andi/ori/xori) zero-extend; everything else sign-extends
    function automatic logic imm_is_signed(input logic [5:0] op);
        return !(op == OP_ANDI || op == OP_ORI || op == OP_XORI);
    endfunction

endpackage

// File: rtl/mips_controller.sv
// Multicycle MIPS control FSM. Only the state and the retired-instruction
// counter are registers; every control output is decoded from the current
// state (plus IR fields and branch_taken where the datapath needs it).
//
// Cycle counts per instruction class, FETCH through the last state:
//   R/I 5, LW 7, SW 5, BRANCH/J/JAL/JR 4, HALT/unknown opcode 3 then stay/retire.
module mips_controller
    import ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 branch_taken,
    output logic                 pc_write_en,
    output logic                 i_or_d,
    output logic                 mem_write,
    output logic                 mem_to_reg,
    output logic                 ir_write,
    output logic                 reg_dst,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic                 jump_and_link,
    output logic                 is_signed,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           pc_source,
    output logic [5:0]           alu_op,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] instr_count,
    output state_t               state_dbg
);

    state_t state;
    state_t state_next;

    assign state_dbg = state;

    // State register and retired-instruction counter; a return to FETCH retires one instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            instr_count <= '0;
        end else begin
            state <= state_next;
            if (state_next == FETCH) begin
                instr_count <= instr_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    // Next-state and control decode; IR fields are only trusted from DECODE onward
    always_comb begin
        state_next    = state;
        pc_write_en   = 1'b0;
        i_or_d        = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        jump_and_link = 1'b0;
        is_signed     = 1'b0;
        alu_src_b     = ALU_B_REG;
        pc_source     = PC_SRC_ALU;
        alu_op        = ALU_OP_ADD;
        halted        = 1'b0;

        case (state)
            FETCH: begin
                // Instruction address goes out; memory answers next cycle
                i_or_d     = 1'b0;
                state_next = FETCH_LAT;
            end
            FETCH_LAT: begin
                // Capture IR and advance PC by 4 in the same cycle
                ir_write    = 1'b1;
                alu_src_a   = 1'b0;
                alu_src_b   = ALU_B_FOUR;
                pc_source   = PC_SRC_ALU;
                pc_write_en = 1'b1;
                state_next  = DECODE;
            end
            DECODE: begin
                // Precompute branch target; for JAL the ALU produces the link address instead
                alu_src_a = 1'b0;
                alu_src_b = (opcode == OP_JAL) ? ALU_B_FOUR : ALU_B_IMM_SH2;
                case (opcode)
                    OP_RTYPE:  state_next = (funct == FUNCT_JR) ? JR : R_EXEC;
                    OP_J:      state_next = JUMP;
                    OP_JAL:    state_next = JAL;
                    OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
                               state_next = BRANCH;
                    OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_IMM_10:
                               state_next = I_EXEC;
                    OP_LW, OP_SW:
                               state_next = MEM_ADDR;
                    OP_HALT:   state_next = HALT;
                    default:   state_next = FETCH;
                endcase
            end
            R_EXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = ALU_B_REG;
                alu_op     = ALU_OP_RTYPE;
                state_next = R_WB;
            end
            R_WB: begin
                reg_dst    = 1'b1;
                mem_to_reg = 1'b0;
                reg_write  = 1'b1;
                alu_op     = ALU_OP_RTYPE;
                state_next = FETCH;
            end
            JR: begin
                // ALU control passes rs through for funct 08
                alu_src_a   = 1'b1;
                alu_src_b   = ALU_B_REG;
                alu_op      = ALU_OP_RTYPE;
                pc_source   = PC_SRC_ALU;
                pc_write_en = 1'b1;
                state_next  = FETCH;
            end
            I_EXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = ALU_B_IMM;
                alu_op     = opcode;
                is_signed  = imm_is_signed(opcode);
                state_next = I_WB;
            end
            I_WB: begin
                reg_dst    = 1'b0;
                mem_to_reg = 1'b0;
                reg_write  = 1'b1;
                alu_op     = opcode;
                is_signed  = imm_is_signed(opcode);
                state_next = FETCH;
            end
            BRANCH: begin
                // Compare rs/rt; target was parked in ALU_OUT during DECODE
                alu_src_a   = 1'b1;
                alu_src_b   = ALU_B_REG;
                alu_op      = opcode;
                pc_source   = PC_SRC_ALU_OUT;
                pc_write_en = branch_taken;
                state_next  = FETCH;
            end
            JUMP: begin
                pc_source   = PC_SRC_JUMP;
                pc_write_en = 1'b1;
                state_next  = FETCH;
            end
            JAL: begin
                jump_and_link = 1'b1;
                reg_write     = 1'b1;
                mem_to_reg    = 1'b0;
                pc_source     = PC_SRC_JUMP;
                pc_write_en   = 1'b1;
                state_next    = FETCH;
            end
            MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = ALU_B_IMM;
                is_signed  = 1'b1;
                state_next = (opcode == OP_SW) ? SW_WR : LW_RD;
            end
            LW_RD: begin
                i_or_d     = 1'b1;
                state_next = LW_WAIT;
            end
            LW_WAIT: begin
                // Synchronous memory: read data lands at the end of this cycle
                i_or_d     = 1'b1;
                state_next = LW_WB;
            end
            LW_WB: begin
                reg_dst    = 1'b0;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            SW_WR: begin
                i_or_d     = 1'b1;
                mem_write  = 1'b1;
                state_next = FETCH;
            end
            HALT: begin
                halted     = 1'b1;
                state_next = HALT;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_controller.sv
// Directed bench for the multicycle MIPS controller: walks each instruction
// class state by state and checks the full control vector, the FSM state and
// the retired-instruction counter against hand-written expectations.
module tb_mips_controller;
    import ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        branch_taken;
    logic        pc_write_en;
    logic        i_or_d;
    logic        mem_write;
    logic        mem_to_reg;
    logic        ir_write;
    logic        reg_dst;
    logic        reg_write;
    logic        alu_src_a;
    logic        jump_and_link;
    logic        is_signed;
    logic [1:0]  alu_src_b;
    logic [1:0]  pc_source;
    logic [5:0]  alu_op;
    logic        halted;
    logic [31:0] instr_count;
    state_t      state_dbg;

    int tests_run;
    int tests_failed;

    mips_controller #(.CNT_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .funct         (funct),
        .branch_taken  (branch_taken),
        .pc_write_en   (pc_write_en),
        .i_or_d        (i_or_d),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .jump_and_link (jump_and_link),
        .is_signed     (is_signed),
        .alu_src_b     (alu_src_b),
        .pc_source     (pc_source),
        .alu_op        (alu_op),
        .halted        (halted),
        .instr_count   (instr_count),
        .state_dbg     (state_dbg)
    );

    // Clock: 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pack a control vector:
    // {pcw, iord, memw, m2r, irw, rdst, rw, asa, jal, sgn, asb[1:0], pcs[1:0], aop[5:0], hlt}
    function automatic logic [20:0] cv(
        input logic pcw, input logic iord, input logic memw, input logic m2r,
        input logic irw, input logic rdst, input logic rw, input logic asa,
        input logic jal, input logic sgn, input logic [1:0] asb,
        input logic [1:0] pcs, input logic [5:0] aop, input logic hlt);
        return {pcw, iord, memw, m2r, irw, rdst, rw, asa, jal, sgn, asb, pcs, aop, hlt};
    endfunction

    function automatic logic [20:0] dut_cv();
        return {pc_write_en, i_or_d, mem_write, mem_to_reg, ir_write, reg_dst,
                reg_write, alu_src_a, jump_and_link, is_signed, alu_src_b,
                pc_source, alu_op, halted};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input state_t exp_state, input logic [20:0] exp);
        chk({tag, "_state"}, 32'(state_dbg), 32'(exp_state));
        chk({tag, "_ctrl"}, 32'(dut_cv()), 32'(exp));
    endtask

    // Advance one clock and settle away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected vectors for the common states
    localparam logic [20:0] V_FETCH   = 21'({1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,6'h3E,1'b0});
    localparam logic [20:0] V_FLAT    = 21'({1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,6'h3E,1'b0});
    localparam logic [20:0] V_DEC     = 21'({1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,6'h3E,1'b0});
    localparam logic [20:0] V_DEC_JAL = 21'({1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,6'h3E,1'b0});

    // FETCH -> FETCH_LAT -> DECODE with the given IR fields, leaves bench in DECODE
    task automatic front(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic [20:0] dec_exp);
        opcode = op;
        funct  = fn;
        chk_ctrl({tag, "_fetch"}, FETCH, V_FETCH);
        step();
        chk_ctrl({tag, "_flat"}, FETCH_LAT, V_FLAT);
        step();
        chk_ctrl({tag, "_decode"}, DECODE, dec_exp);
        step();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        opcode       = 6'h00;
        funct        = 6'h00;
        branch_taken = 1'b0;

        // Reset state
        step();
        step();
        chk_ctrl("reset", FETCH, V_FETCH);
        chk("reset_count", instr_count, 32'd0);
        rst = 1'b0;

        // R-type addu (funct 21): 5 cycles
        front("r", 6'h00, 6'h21, V_DEC);
        chk_ctrl("r_exec", R_EXEC, cv(0,0,0,0,0,0,0,1,0,0,2'b00,2'b00,6'h00,0));
        chk("r_exec_count", instr_count, 32'd0);
        step();
        chk_ctrl("r_wb", R_WB, cv(0,0,0,0,0,1,1,0,0,0,2'b00,2'b00,6'h00,0));
        step();
        chk_ctrl("r_done", FETCH, V_FETCH);
        chk("r_count", instr_count, 32'd1);

        // LW: memory address, two read cycles, writeback
        front("lw", 6'h23, 6'h00, V_DEC);
        chk_ctrl("lw_addr", MEM_ADDR, cv(0,0,0,0,0,0,0,1,0,1,2'b10,2'b00,6'h3E,0));
        step();
        chk_ctrl("lw_rd", LW_RD, cv(0,1,0,0,0,0,0,0,0,0,2'b00,2'b00,6'h3E,0));
        step();
        chk_ctrl("lw_wait", LW_WAIT, cv(0,1,0,0,0,0,0,0,0,0,2'b00,2'b00,6'h3E,0));
        step();
        chk_ctrl("lw_wb", LW_WB, cv(0,0,0,1,0,0,1,0,0,0,2'b00,2'b00,6'h3E,0));
        step();
        chk("lw_count", instr_count, 32'd2);

        // SW: mem_write only in SW_WR
        front("sw", 6'h2B, 6'h00, V_DEC);
        chk_ctrl("sw_addr", MEM_ADDR, cv(0,0,0,0,0,0,0,1,0,1,2'b10,2'b00,6'h3E,0));
        step();
        chk_ctrl("sw_wr", SW_WR, cv(0,1,1,0,0,0,0,0,0,0,2'b00,2'b00,6'h3E,0));
        step();
        chk_ctrl("sw_done", FETCH, V_FETCH);
        chk("sw_count", instr_count, 32'd3);

        // BEQ taken, then not taken
        branch_taken = 1'b1;
        front("beq_t", 6'h04, 6'h00, V_DEC);
        chk_ctrl("beq_t_br", BRANCH, cv(1,0,0,0,0,0,0,1,0,0,2'b00,2'b01,6'h04,0));
        step();
        chk("beq_t_count", instr_count, 32'd4);
        branch_taken = 1'b0;
        front("beq_n", 6'h04, 6'h00, V_DEC);
        chk_ctrl("beq_n_br", BRANCH, cv(0,0,0,0,0,0,0,1,0,0,2'b00,2'b01,6'h04,0));
        step();
        chk("beq_n_count", instr_count, 32'd5);

        // JAL: link computed in DECODE, jump + link write in JAL
        front("jal", 6'h03, 6'h00, V_DEC_JAL);
        chk_ctrl("jal_st", JAL, cv(1,0,0,0,0,0,1,0,1,0,2'b00,2'b10,6'h3E,0));
        step();
        chk("jal_count", instr_count, 32'd6);

        // JR
        front("jr", 6'h00, 6'h08, V_DEC);
        chk_ctrl("jr_st", JR, cv(1,0,0,0,0,0,0,1,0,0,2'b00,2'b00,6'h00,0));
        step();
        chk("jr_count", instr_count, 32'd7);

        // ORI: zero-extended immediate
        front("ori", 6'h0D, 6'h00, V_DEC);
        chk_ctrl("ori_exec", I_EXEC, cv(0,0,0,0,0,0,0,1,0,0,2'b10,2'b00,6'h0D,0));
        step();
        chk_ctrl("ori_wb", I_WB, cv(0,0,0,0,0,0,1,0,0,0,2'b00,2'b00,6'h0D,0));
        step();
        chk("ori_count", instr_count, 32'd8);

        // SLTI: sign-extended immediate
        front("slti", 6'h0A, 6'h00, V_DEC);
        chk_ctrl("slti_exec", I_EXEC, cv(0,0,0,0,0,0,0,1,0,1,2'b10,2'b00,6'h0A,0));
        step();
        step();
        chk("slti_count", instr_count, 32'd9);

        // Illegal opcode 3A: retires as a NOP straight from DECODE
        front("ill", 6'h3A, 6'h00, V_DEC);
        chk_ctrl("ill_done", FETCH, V_FETCH);
        chk("ill_count", instr_count, 32'd10);

        // Reset in the middle of LW_WAIT takes effect without waiting for a clock
        front("lwr", 6'h23, 6'h00, V_DEC);
        step();
        step();
        chk("lwr_in_wait", 32'(state_dbg), 32'(LW_WAIT));
        rst = 1'b1;
        #1;
        chk_ctrl("lwr_abort", FETCH, V_FETCH);
        chk("lwr_abort_count", instr_count, 32'd0);
        step();
        rst = 1'b0;
        chk_ctrl("lwr_held", FETCH, V_FETCH);

        // One R-type so the counter is non-zero, then HALT for 100 cycles
        front("r2", 6'h00, 6'h20, V_DEC);
        step();
        step();
        chk("r2_count", instr_count, 32'd1);
        front("halt", 6'h3F, 6'h00, V_DEC);
        for (int i = 0; i < 100; i++) begin
            chk_ctrl("halt_hold", HALT, cv(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,6'h3E,1));
            chk("halt_count", instr_count, 32'd1);
            step();
        end

        // Only reset leaves HALT
        rst = 1'b1;
        #1;
        chk_ctrl("halt_exit", FETCH, V_FETCH);
        chk("halt_exit_count", instr_count, 32'd0);
        step();
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
